// File: rtl/round_arb_pkg.sv
// Shared definitions for the round-robin arbiter: default requester count and index helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package round_arb_pkg;

    // Default number of requesters.
    localparam int ARB_N_DEFAULT = 4;

    // Widest requester vector the index helper understands; arbiters must keep N within this.
    localparam int ARB_MAX_N = 64;
    localparam int ARB_IDX_W = $clog2(ARB_MAX_N);

    // Binary index of the set bit in a one-hot vector (zero when the vector is empty).
    function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] vec);
        logic [ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (vec[i]) begin
                idx = idx | ARB_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating priority pick: one-hot of the first set req bit searching from ptr upward, modulo N.
// Latency: purely combinational.
// Backpressure: none; the result is recomputed from req and ptr every cycle.
module rr_prio_pick
    import round_arb_pkg::*;
#(
    parameter  int N     = ARB_N_DEFAULT,
    localparam int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     next_gnt
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] pick_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   pick_rot;

    // Rotate req so ptr lands on bit 0, isolate the lowest set bit, then rotate back.
    always_comb begin
        req_dbl  = {req, req} >> ptr;
        req_rot  = req_dbl[N-1:0];
        pick_rot = req_rot & (~req_rot + ONE);
        pick_dbl = {pick_rot, pick_rot} << ptr;
        next_gnt = pick_dbl[2*N-1:N];
    end

endmodule

// File: rtl/round_robin_arb.sv
// N-way round-robin arbiter with a registered one-hot grant; ROUND_ARB_LOCK_EN adds grant hold.
// Latency: one cycle from req sampled at an edge to gnt after that edge.
// Backpressure: none; requesters hold req until they see their gnt bit (or release it when locked).
module round_robin_arb
    import round_arb_pkg::*;
#(
    parameter  int N     = ARB_N_DEFAULT,
    localparam int PTR_W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic [PTR_W-1:0] win_idx;
    logic [N-1:0]     pick;
    logic [N-1:0]     gnt_nxt;
`ifdef ROUND_ARB_LOCK_EN
    logic             hold;
`endif

    rr_prio_pick #(.N(N)) u_pick (
        .req      (req),
        .ptr      (ptr),
        .next_gnt (pick)
    );

    // Next grant and pointer: winner moves to lowest priority; an idle cycle leaves ptr alone.
    always_comb begin
        win_idx = PTR_W'(onehot_to_idx(ARB_MAX_N'(pick)));
        gnt_nxt = pick;
        ptr_nxt = ptr;
        if (pick != '0) begin
            ptr_nxt = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_ONE;
        end
`ifdef ROUND_ARB_LOCK_EN
        // Current owner still requesting keeps the resource; ptr already points past it.
        hold = |(gnt & req);
        if (hold) begin
            gnt_nxt = gnt;
            ptr_nxt = ptr;
        end
`endif
    end

    // Grant and pointer registers; reset clears the grant the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt <= '0;
            ptr <= '0;
        end else begin
            gnt <= gnt_nxt;
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_round_robin_arb.sv
// Self-checking bench for round_robin_arb: directed plan sequences plus randomized requests.
// Latency: expectations are due one clock after the req they were computed from.
// Backpressure: none; stimulus is pushed to a queue and a negedge monitor compares.
module tb_round_robin_arb;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] exp;
        int           due;
    } item_t;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    item_t exp_q[$];

    // Reference state: priority start index and last granted vector.
    int           m_ptr = 0;
    logic [N-1:0] m_gnt = '0;
`ifndef ROUND_ARB_LOCK_EN
    int           waits[N];
`endif

    round_robin_arb #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare every expectation when it falls due.
    always @(negedge clk) begin
        item_t it;
        while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            it = exp_q.pop_front();
            chk("gnt", gnt, it.exp);
            chk("onehot0", $countones(gnt) <= 1, 1);
            chk("zero_iff_idle", gnt == '0, it.req == '0);
`ifndef ROUND_ARB_LOCK_EN
            for (int i = 0; i < N; i++) begin
                if (it.req[i] && !gnt[i]) begin
                    waits[i]++;
                    chk("starve", waits[i] < N, 1);
                end else begin
                    waits[i] = 0;
                end
            end
`endif
        end
    end

    // Drive one cycle of req; queue either the plan literal or the reference model's answer.
    task automatic step(input logic [N-1:0] r, input bit use_lit, input logic [N-1:0] lit);
        logic [N-1:0] e;
        item_t        it;
        req = r;
        e   = '0;
`ifdef ROUND_ARB_LOCK_EN
        if ((m_gnt & r) != '0) begin
            e = m_gnt;
        end else
`endif
        begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (r[idx] && e == '0) begin
                    e[idx] = 1'b1;
                    m_ptr  = (idx + 1) % N;
                end
            end
        end
        m_gnt  = e;
        it.req = r;
        it.exp = use_lit ? lit : e;
        it.due = cyc + 1;
        exp_q.push_back(it);
        @(negedge clk);
    endtask

    // Assert reset away from the clock edge, check the grant drops at once and stays low.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        req = '1;
        #1;
        chk("rst_async", gnt, 0);
        m_ptr = 0;
        m_gnt = '0;
`ifndef ROUND_ARB_LOCK_EN
        for (int i = 0; i < N; i++) waits[i] = 0;
`endif
        @(posedge clk);
        #1;
        chk("rst_hold", gnt, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] r;
        rst = 1'b0;
        req = '0;
        do_reset();

`ifndef ROUND_ARB_LOCK_EN
        // Full contention rotates through every requester.
        step(4'b1111, 1, 4'b0001);
        step(4'b1111, 1, 4'b0010);
        step(4'b1111, 1, 4'b0100);
        step(4'b1111, 1, 4'b1000);
        step(4'b1111, 1, 4'b0001);

        // Sparse: bit 1 never requested, never granted.
        do_reset();
        step(4'b1101, 1, 4'b0001);
        step(4'b1101, 1, 4'b0100);
        step(4'b1101, 1, 4'b1000);
        step(4'b1101, 1, 4'b0001);

        // Idle cycles keep the pointer; search from 2 wraps to 0.
        do_reset();
        step(4'b0010, 1, 4'b0010);
        step(4'b0000, 1, 4'b0000);
        step(4'b0000, 1, 4'b0000);
        step(4'b0000, 1, 4'b0000);
        step(4'b0011, 1, 4'b0001);

        // Single requester granted every cycle; win by N-1 wraps ptr to 0.
        do_reset();
        step(4'b1000, 1, 4'b1000);
        step(4'b1000, 1, 4'b1000);
        step(4'b1000, 1, 4'b1000);
        step(4'b1001, 1, 4'b0001);
`else
        // Lock: owner keeps the grant while it requests; arbitration resumes past it.
        step(4'b0011, 1, 4'b0001);
        step(4'b0011, 1, 4'b0001);
        step(4'b0011, 1, 4'b0001);
        step(4'b0010, 1, 4'b0010);
        step(4'b0011, 1, 4'b0010);
        step(4'b0001, 1, 4'b0001);
        step(4'b0000, 1, 4'b0000);
`endif

        // Randomized traffic against the reference model, with a mid-run reset.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            if (n == 150) do_reset();
            r = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
            step(r, 0, '0);
        end

        #1;
        chk("drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/round_robin_arb.md
Name: round_robin_arb

Overview:
- Parameterised N-requester round-robin arbiter with a registered one-hot grant.
- Sits in front of a shared resource (bus, memory port, FIFO write side). Picks one active requester per cycle and rotates priority so that every requester holding its request is served within N cycles.
- Default configuration: 4 requesters.

Parameters:
- N, 4, number of requesters (≥2); sets the width of req/gnt.
- PTR_W, $clog2(N), width of the internal priority pointer (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i = requester i wants the resource this cycle.
- gnt  output  N  registered one-hot grant; bit i = requester i owns the resource this cycle.

Behaviour:
- Reset: on rst asserted, immediately gnt=0 and priority pointer ptr=0, so req[0] has highest priority. Release of rst is synchronous to clk.
- Arbitration (combinational):
  - search order starts at index ptr and goes ptr, ptr+1, … N-1, 0, … ptr-1 (modulo N);
  - first set req bit in that order wins, giving next_gnt (one-hot);
  - if req==0, next_gnt=0.
- Latency: one cycle. gnt at edge k+1 reflects req sampled at edge k; gnt is a flop output, never combinational from req.
- Pointer update at each clk edge:
  - if next_gnt has bit w set, ptr <= (w+1) mod N, so the winner gets lowest priority next;
  - if next_gnt==0, ptr holds.
- No handshake: a requester must keep req high until it observes its gnt bit. Dropping req before grant forfeits the request.
- gnt is always one-hot or zero; never multiple bits.
- Grant is one cycle per win. With the optional feature off, a requester still asserting after its grant loses priority to any other active requester.
- Single active requester: granted every cycle continuously, regardless of ptr.
- Wrap-around: win by N-1 sets ptr=0.
- Reset mid-operation: gnt clears asynchronously the same instant; ptr returns to 0.
- Unknown/X on req is not handled specially.

Optional Feature:
- Macro: ROUND_ARB_LOCK_EN.
- Defined: if the current gnt holder (bit g) still has req[g]=1 at the clk edge, gnt and ptr stay unchanged (bus lock / burst hold). Arbitration resumes the cycle after req[g] drops, with ptr=(g+1) mod N.
- Undefined: behaviour exactly as in Behaviour; no hold.

Decomposition:
- Shared package round_arb_pkg holds:
  - localparam default N (4);
  - function onehot_to_idx(N-bit) returning PTR_W index;
  - function rotate helpers if desired.
- One sub-module, rr_prio_pick: purely combinational. Inputs req and ptr; output one-hot next_gnt. Use the double-width masked / rotated priority-encoder technique.
- Top round_robin_arb holds gnt/ptr flops and the lock logic.

Test Plan:
- Reset: assert rst with req=4'b1111 → gnt=4'b0000 immediately. After release, first edge gives gnt=4'b0001.
- Full contention: req=4'b1111 held from reset → gnt sequence 0001, 0010, 0100, 1000, 0001 on successive cycles.
- Sparse: req=4'b1101 held from reset → gnt 0001, 0100, 1000, 0001. Bit 1 is never granted.
- Idle holds pointer: grant 0010 (ptr=2), then req=0000 for 3 cycles (gnt=0000), then req=4'b0011 → gnt=0001 (search starts at 2 and wraps to 0).
- Single requester: req=4'b1000 held → gnt=1000 every cycle. Then req=4'b1001 → gnt=0001 (ptr wrapped to 0).
- Random: 50+ cycles of random req, with scoreboard checks:
  - gnt one-hot or zero;
  - gnt==0 iff previous req==0;
  - no active requester waits more than N cycles.
  - With ROUND_ARB_LOCK_EN, req=4'b0011 held → gnt stays 0001 until req[0] drops, then 0010.
